id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/id_ex_if.sv | 39 +++
 rtl/id_ex_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/id_ex_if.sv
// Decode-to-execute bundle: decode operands/controls, hazard-unit controls,
// forwarded results, and the registered execute-side outputs.
interface id_ex_if #(parameter int XLEN = 32);
  logic            StallE, FlushE;
  logic [XLEN-1:0] RD1D, RD2D, ImmExtD, PCD, PCPlus4D;
  logic [4:0]      Rs1D, Rs2D, RdD;
  logic            RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD;
  logic [1:0]      ResultSrcD;
  logic [2:0]      ALUControlD;
  logic [1:0]      ForwardAE, ForwardBE;
  logic [XLEN-1:0] ALUResultM, ResultW;

  logic [XLEN-1:0] SrcAE, SrcBE, WriteDataE;
  logic [2:0]      AluControlE;
  logic [XLEN-1:0] ImmExtE, PCE, PCPlus4E;
  logic [4:0]      Rs1E, Rs2E, RdE;
  logic            RegWriteE, MemWriteE, JumpE, BranchE, ValidE;
  logic [1:0]      ResultSrcE;
  logic            IllegalOpE;
  logic [15:0]     FlushCount;

  modport master (
    output StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, ResultSrcD,
           ALUControlD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    input  SrcAE, SrcBE, WriteDataE, AluControlE, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ValidE,
           ResultSrcE, IllegalOpE, FlushCount
  );

  modport slave (
    input  StallE, FlushE, RD1D, RD2D, ImmExtD, PCD, PCPlus4D, Rs1D, Rs2D, RdD,
           RegWriteD, MemWriteD, JumpD, BranchD, ALUSrcD, ValidD, ResultSrcD,
           ALUControlD, ForwardAE, ForwardBE, ALUResultM, ResultW,
    output SrcAE, SrcBE, WriteDataE, AluControlE, ImmExtE, PCE, PCPlus4E,
           Rs1E, Rs2E, RdE, RegWriteE, MemWriteE, JumpE, BranchE, ValidE,
           ResultSrcE, IllegalOpE, FlushCount
  );
endinterface

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall control, operand forwarding muxes,
// illegal-ALU-op detection and a saturating flush-event counter.
module id_ex_stage #(
  parameter int XLEN = 32
) (
  input  logic   clk,
  input  logic   reset,
  id_ex_if.slave bus
);

  typedef struct packed {
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] pc_plus4;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic            reg_write;
    logic            mem_write;
    logic            jump;
    logic            branch;
    logic            alu_src;
    logic            valid;
    logic [1:0]      result_src;
    logic [2:0]      alu_ctrl;
  } ex_regs_t;

  ex_regs_t    ex_q, ex_d;
  logic [15:0] flush_cnt_q, flush_cnt_d;
  logic [XLEN-1:0] write_data;

  always_comb begin
    ex_d        = ex_q;
    flush_cnt_d = flush_cnt_q;
    if (bus.FlushE) begin
      // A bubble zeroes the register indices too, so x0 never matches a forward.
      ex_d = '0;
      if (flush_cnt_q != 16'hFFFF) flush_cnt_d = flush_cnt_q + 16'd1;
    end else if (!bus.StallE) begin
      ex_d.rd1        = bus.RD1D;
      ex_d.rd2        = bus.RD2D;
      ex_d.imm        = bus.ImmExtD;
      ex_d.pc         = bus.PCD;
      ex_d.pc_plus4   = bus.PCPlus4D;
      ex_d.rs1        = bus.Rs1D;
      ex_d.rs2        = bus.Rs2D;
      ex_d.rd         = bus.RdD;
      ex_d.reg_write  = bus.RegWriteD;
      ex_d.mem_write  = bus.MemWriteD;
      ex_d.jump       = bus.JumpD;
      ex_d.branch     = bus.BranchD;
      ex_d.alu_src    = bus.ALUSrcD;
      ex_d.valid      = bus.ValidD;
      ex_d.result_src = bus.ResultSrcD;
      ex_d.alu_ctrl   = bus.ALUControlD;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ex_q        <= '0;
      flush_cnt_q <= '0;
    end else begin
      ex_q        <= ex_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Forwarding is purely combinational so a stalled instruction re-selects each cycle.
  always_comb begin
    unique case (bus.ForwardAE)
      2'b01:   bus.SrcAE = bus.ResultW;
      2'b10:   bus.SrcAE = bus.ALUResultM;
      default: bus.SrcAE = ex_q.rd1;
    endcase
    unique case (bus.ForwardBE)
      2'b01:   write_data = bus.ResultW;
      2'b10:   write_data = bus.ALUResultM;
      default: write_data = ex_q.rd2;
    endcase
  end

  assign bus.WriteDataE  = write_data;
  assign bus.SrcBE       = ex_q.alu_src ? ex_q.imm : write_data;
  assign bus.AluControlE = ex_q.alu_ctrl;
  assign bus.IllegalOpE  = ex_q.valid &&
                           (ex_q.alu_ctrl inside {3'b100, 3'b110, 3'b111});
  assign bus.ImmExtE     = ex_q.imm;
  assign bus.PCE         = ex_q.pc;
  assign bus.PCPlus4E    = ex_q.pc_plus4;
  assign bus.Rs1E        = ex_q.rs1;
  assign bus.Rs2E        = ex_q.rs2;
  assign bus.RdE         = ex_q.rd;
  assign bus.RegWriteE   = ex_q.reg_write;
  assign bus.MemWriteE   = ex_q.mem_write;
  assign bus.JumpE       = ex_q.jump;
  assign bus.BranchE     = ex_q.branch;
  assign bus.ValidE      = ex_q.valid;
  assign bus.ResultSrcE  = ex_q.result_src;
  assign bus.FlushCount  = flush_cnt_q;

endmodule
